// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream packet receiver.
package axis_pkg;

   localparam int unsigned AXIS_DATA_W = 32;

   typedef struct packed {
      logic                   last;
      logic [AXIS_DATA_W-1:0] data;
   } axis_beat_t;

   typedef enum logic {
      RX_IDLE   = 1'b0,
      RX_IN_PKT = 1'b1
   } axis_rx_state_e;

   // True when v is a power of two no smaller than 2.
   function automatic logic is_pow2_ge2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_pkt_rx: register array, synchronous write, asynchronous read.
module axis_fifo_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W:0]            wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [DATA_W:0]            rd_data_c
);

   logic [DATA_W:0] mem_q [DEPTH];

   // Store one {last, data} entry per accepted beat.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/axis_pkt_rx.sv
// AXI-Stream packet receiver: FIFO with tlast, FWFT read port, occupancy/packet counters.
// Optional store-and-forward release gate: define AXIS_PKT_RX_STORE_FWD_EN.
module axis_pkt_rx
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_DATA_W,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     aclk,
   input  logic                     areset_n,
   input  logic                     tvalid,
   output logic                     tready,
   input  logic [DATA_W-1:0]        tdata,
   input  logic                     tlast,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_last,
   output logic [$clog2(DEPTH):0]   level,
   output logic [$clog2(DEPTH):0]   pkt_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
      $error("axis_pkt_rx: DEPTH must be a power of 2 and at least 2");
   end

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   level_q, level_d;
   logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic            tready_q, tready_d;
   logic            rd_valid_q, rd_valid_d;
   logic [DATA_W:0] head_q, head_d;
   axis_rx_state_e  state_q, state_d;

   logic            push;
   logic            pop;
   logic            empty_d;
   logic            full_d;
   logic [DATA_W:0] mem_rd_c;

   assign push = tvalid & tready_q;
   assign pop  = rd_en & rd_valid_q;

   axis_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk       (aclk),
      .wr_en     (push),
      .wr_addr   (wr_ptr_q[AW-1:0]),
      .wr_data   ({tlast, tdata}),
      .rd_addr   (rd_ptr_d[AW-1:0]),
      .rd_data_c (mem_rd_c)
   );

   // Next-state: pointers, counters, rx FSM, and the registered read-side view.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      pkt_cnt_d  = pkt_cnt_q;
      state_d    = state_q;
      head_d     = head_q;
      empty_d    = 1'b1;
      full_d     = 1'b0;
      tready_d   = 1'b1;
      rd_valid_d = 1'b0;

      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + PW'(push) - PW'(pop);

      case ({push & tlast, pop & head_q[DATA_W]})
         2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

      case (state_q)
         RX_IDLE:   if (push && !tlast) state_d = RX_IN_PKT;
         RX_IN_PKT: if (push && tlast)  state_d = RX_IDLE;
         default:   state_d = RX_IDLE;
      endcase

      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
      tready_d = !full_d;

`ifdef AXIS_PKT_RX_STORE_FWD_EN
      rd_valid_d = !empty_d && ((pkt_cnt_d != '0) || (full_d && (state_d == RX_IN_PKT)));
`else
      rd_valid_d = !empty_d;
`endif

      // The incoming beat becomes head when every older entry is gone after this edge.
      if (!empty_d) begin
         if (push && (level_q == PW'(pop))) begin
            head_d = {tlast, tdata};
         end else begin
            head_d = mem_rd_c;
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         pkt_cnt_q  <= '0;
         state_q    <= RX_IDLE;
         tready_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         head_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         pkt_cnt_q  <= pkt_cnt_d;
         state_q    <= state_d;
         tready_q   <= tready_d;
         rd_valid_q <= rd_valid_d;
         head_q     <= head_d;
      end
   end

   assign tready   = tready_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = head_q[DATA_W-1:0];
   assign rd_last  = head_q[DATA_W];
   assign level    = level_q;
   assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Self-checking bench for axis_pkt_rx against a queue-based reference model.
module tb_axis_pkt_rx;
   import axis_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 16;

   logic              aclk = 1'b0;
   logic              areset_n;
   logic              tvalid = 1'b0;
   logic              tready;
   logic [DATA_W-1:0] tdata = '0;
   logic              tlast = 1'b0;
   logic              rd_en = 1'b0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic [4:0]        level;
   logic [4:0]        pkt_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   axis_beat_t q[$];
   axis_beat_t m_head;
   bit         m_inpkt;
   bit         m_tready;
   bit         m_rdv;

   axis_pkt_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .aclk     (aclk),
      .areset_n (areset_n),
      .tvalid   (tvalid),
      .tready   (tready),
      .tdata    (tdata),
      .tlast    (tlast),
      .rd_en    (rd_en),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_last  (rd_last),
      .level    (level),
      .pkt_cnt  (pkt_cnt)
   );

   always #5 aclk = ~aclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic int model_pkts();
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return n;
   endfunction

   function automatic bit model_valid();
      if (q.size() == 0) return 1'b0;
`ifdef AXIS_PKT_RX_STORE_FWD_EN
      return (model_pkts() != 0) || ((q.size() == DEPTH) && m_inpkt);
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tready",   64'(tready),   64'(m_tready));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk("level",    64'(level),    64'(q.size()));
      chk("pkt_cnt",  64'(pkt_cnt),  64'(model_pkts()));
      chk("rd_data",  64'(rd_data),  64'(m_head.data));
      chk("rd_last",  64'(rd_last),  64'(m_head.last));
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after.
   task automatic cycle(input logic tv, input logic [DATA_W-1:0] td, input logic tl, input logic re);
      bit push, pop;
      tvalid = tv; tdata = td; tlast = tl; rd_en = re;
      push = tv && m_tready;
      pop  = re && m_rdv;
      @(posedge aclk);
      if (pop) q.delete(0);
      if (push) begin
         q.push_back('{last: tl, data: td});
         m_inpkt = !tl;
      end
      if (q.size() != 0) m_head = q[0];
      m_tready = (q.size() < DEPTH);
      m_rdv    = model_valid();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      tvalid = 1'b0; rd_en = 1'b0;
      areset_n = 1'b0;
      #1;
      q.delete();
      m_inpkt = 1'b0; m_head = '0; m_tready = 1'b0; m_rdv = 1'b0;
      check_all();
      @(posedge aclk); #1;
      check_all();
      @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk); #1;
      m_tready = 1'b1;
      check_all();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("drain_level", 64'(level), 64'd0);
   endtask

   initial begin
      int k;
      areset_n = 1'b1;
      #2;
      do_reset();

      // Reset mid-stream with three beats stored
      cycle(1'b1, 32'h0000_0001, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0002, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0003, 1'b0, 1'b0);
      do_reset();

      // Single-beat packet
      cycle(1'b1, 32'haaaa_bbbb, 1'b1, 1'b0);
      chk("single_data", 64'(rd_data), 64'h0000_0000_aaaa_bbbb);
      chk("single_pkt",  64'(pkt_cnt), 64'd1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("single_pop_level", 64'(level), 64'd0);
      chk("single_pop_pkt",   64'(pkt_cnt), 64'd0);

      // Underflow: reads while empty are ignored
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("underflow_valid", 64'(rd_valid), 64'd0);
      cycle(1'b1, 32'h5555_0001, 1'b1, 1'b0);
      chk("underflow_next", 64'(rd_data), 64'h0000_0000_5555_0001);
      drain();

      // Fill to capacity, refuse a 17th beat, then drain in order
      for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
      chk("fill_level",  64'(level),  64'd16);
      chk("fill_tready", 64'(tready), 64'd0);
      cycle(1'b1, 32'hdead_beef, 1'b0, 1'b0);
      chk("fill_17th", 64'(level), 64'd16);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("fill_pop_tready", 64'(tready), 64'd1);
      for (int i = 1; i < 16; i++) begin
         chk("fill_order", 64'(rd_data), 64'(i));
         cycle(1'b0, '0, 1'b0, 1'b1);
      end
      chk("fill_empty", 64'(level), 64'd0);
      // Close the open packet so the FSM returns to idle
      cycle(1'b1, 32'h0, 1'b1, 1'b0);
      drain();

      // Simultaneous push and pop at level 5
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h7000_0000 + DATA_W'(i), 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h7100_0000 + DATA_W'(i), 1'b1, 1'b1);
      chk("simul_level", 64'(level), 64'd5);
      drain();

`ifdef AXIS_PKT_RX_STORE_FWD_EN
      // Store-and-forward: partial packet held back until its tlast beat
      cycle(1'b1, 32'hcccc_dddd, 1'b0, 1'b1);
      chk("sf_hold1", 64'(rd_valid), 64'd0);
      cycle(1'b1, 32'hcccc_ddde, 1'b0, 1'b1);
      chk("sf_hold2", 64'(rd_valid), 64'd0);
      cycle(1'b1, 32'hcccc_dddf, 1'b1, 1'b0);
      chk("sf_release", 64'(rd_valid), 64'd1);
      drain();
      // Oversize packet must not deadlock
      k = 0;
      for (int c = 0; c < 400 && k < 20; c++) begin
         bit acc;
         acc = m_tready;
         cycle(1'b1, 32'h1000_0000 + DATA_W'(k), (k == 19), 1'b1);
         if (acc) k++;
      end
      chk("sf_oversize_done", 64'(k), 64'd20);
      drain();
`endif

      // Randomized traffic against the model
      k = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
      end
      cycle(1'b1, 32'h0, 1'b1, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
